// File: rtl/serial_sum_collector.sv
// Assembles the LSB-first serial sum stream into W-bit words held in a one-entry valid/ready register.
// The result is visible one cycle after the final beat; the serial side cannot stall, so a word that completes into a full register is dropped.
module serial_sum_collector #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    input  logic          last,
    input  logic          sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_ovf,
    output logic          drop
);
    logic [W-1:0]  acc;
    logic [LW-1:0] cnt;
    logic          ovf;
    logic          full;
    logic          free;
    logic [W-1:0]  bit_mask;
    logic [W-1:0]  word_dat;
    logic [LW-1:0] word_len;
    logic          word_ovf;

    assign full = (cnt == LW'(W));
    assign free = !out_valid || out_ready;
    // Once cnt reaches W the shift clears the mask, so extra bits fall away.
    assign bit_mask = W'(1) << cnt;
    assign word_dat = sum ? (acc | bit_mask) : acc;
    assign word_len = full ? LW'(W) : cnt + LW'(1);
    assign word_ovf = ovf | full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (vld && last) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
                if (free) begin
                    out_valid <= 1'b1;
                    out_data  <= word_dat;
                    out_len   <= word_len;
                    out_ovf   <= word_ovf;
                end else begin
                    drop <= 1'b1;
                end
            end else begin
                if (vld) begin
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        acc <= word_dat;
                        cnt <= cnt + LW'(1);
                    end
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule
